// File: rtl/vga_plot_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_plot_sink_if                                          |
// | Purpose  : pixel plot stream (coordinate, 3-bit RGB, write strobe)   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface vga_plot_sink_if #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 8
);
    logic [X_BITS-1:0] iX;
    logic [Y_BITS-1:0] iY;
    logic [2:0]        iR;
    logic [2:0]        iG;
    logic [2:0]        iB;
    logic              iPlot;

    modport master (output iX, iY, iR, iG, iB, iPlot);
    modport slave  (input  iX, iY, iR, iG, iB, iPlot);
endinterface
`default_nettype wire

// File: rtl/vga_plot_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : vga_plot_sink                                             |
// | Purpose  : framebuffer for the plot stream, scanned out as VGA       |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module vga_plot_sink #(
    parameter int X_BITS    = 8,
    parameter int Y_BITS    = 8,
    parameter int H_OFFSET  = 192,
    parameter int V_OFFSET  = 112,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic                     clock,
    input  logic                     not_reset,
    vga_plot_sink_if.slave           plot_i,
    output logic [7:0]               oVgaR,
    output logic [7:0]               oVgaG,
    output logic [7:0]               oVgaB,
    output logic                     oHsync,
    output logic                     oVsync,
    output logic                     oBlankN,
    output logic                     oPixelEn,
    output logic                     oFrameStart,
    output logic [X_BITS+Y_BITS:0]   oPlotCount
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int A_W     = X_BITS + Y_BITS;
    localparam int DEPTH   = 1 << A_W;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);

    localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
    localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);
    localparam logic [31:0] H_WIN_LO = 32'(H_OFFSET);
    localparam logic [31:0] H_WIN_HI = 32'(H_OFFSET + (1 << X_BITS));
    localparam logic [31:0] V_WIN_LO = 32'(V_OFFSET);
    localparam logic [31:0] V_WIN_HI = 32'(V_OFFSET + (1 << Y_BITS));

    localparam logic [A_W:0] CNT_MAX = {1'b1, {A_W{1'b0}}};

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    // ------------------------------------------------------------------
    // Pixel tick divider and scan counters
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [HC_W-1:0]  hcnt_q, hcnt_d;
    logic [VC_W-1:0]  vcnt_q, vcnt_d;
    logic             tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (tick) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VC_W'(1);
            end else begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            div_q  <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign oPixelEn    = tick;
    assign oFrameStart = tick && (hcnt_q == '0) && (vcnt_q == '0);

    // ------------------------------------------------------------------
    // Stage 0: timing decode straight from the counters
    // ------------------------------------------------------------------
    logic [31:0]    w_h32, w_v32;
    logic           w_hs_act, w_vs_act, w_act, w_win;
    logic [A_W-1:0] w_raddr;

    assign w_h32    = 32'(hcnt_q);
    assign w_v32    = 32'(vcnt_q);
    assign w_hs_act = (w_h32 >= HS_START) && (w_h32 < HS_END);
    assign w_vs_act = (w_v32 >= VS_START) && (w_v32 < VS_END);
    assign w_act    = (w_h32 < H_VIS) && (w_v32 < V_VIS);
    assign w_win    = (w_h32 >= H_WIN_LO) && (w_h32 < H_WIN_HI) &&
                      (w_v32 >= V_WIN_LO) && (w_v32 < V_WIN_HI);
    assign w_raddr  = {Y_BITS'(w_v32 - V_WIN_LO), X_BITS'(w_h32 - H_WIN_LO)};

    // ------------------------------------------------------------------
    // Framebuffer: contents come from the configuration image and survive
    // reset, so neither port has a reset term.
    // ------------------------------------------------------------------
    logic [8:0] fb_mem [DEPTH];
    logic [8:0] rd_q;

    always_ff @(posedge clock) begin
        if (plot_i.iPlot) begin
            fb_mem[{plot_i.iY, plot_i.iX}] <= {plot_i.iR, plot_i.iG, plot_i.iB};
        end
    end

    // Same-clock read of a freshly written address sees the old word.
    always_ff @(posedge clock) begin
        if (tick) begin
            rd_q <= fb_mem[w_raddr];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: flags travelling alongside the RAM read
    // ------------------------------------------------------------------
    logic hs1_q, vs1_q, act1_q, win1_q;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            act1_q <= 1'b0;
            win1_q <= 1'b0;
        end else if (tick) begin
            hs1_q  <= w_hs_act;
            vs1_q  <= w_vs_act;
            act1_q <= w_act;
            win1_q <= w_win;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers, all two ticks behind the counters
    // ------------------------------------------------------------------
    logic       hsync_q, vsync_q, blank_n_q;
    logic [7:0] red_q, grn_q, blu_q;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_n_q <= 1'b0;
            red_q     <= 8'h00;
            grn_q     <= 8'h00;
            blu_q     <= 8'h00;
        end else if (tick) begin
            hsync_q   <= ~hs1_q;
            vsync_q   <= ~vs1_q;
            blank_n_q <= act1_q;
            if (act1_q && win1_q) begin
                red_q <= expand3(rd_q[8:6]);
                grn_q <= expand3(rd_q[5:3]);
                blu_q <= expand3(rd_q[2:0]);
            end else begin
                red_q <= 8'h00;
                grn_q <= 8'h00;
                blu_q <= 8'h00;
            end
        end
    end

    assign oHsync  = hsync_q;
    assign oVsync  = vsync_q;
    assign oBlankN = blank_n_q;
    assign oVgaR   = red_q;
    assign oVgaG   = grn_q;
    assign oVgaB   = blu_q;

    // ------------------------------------------------------------------
    // Accepted-plot counter, saturating at the framebuffer size
    // ------------------------------------------------------------------
    logic [A_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (plot_i.iPlot && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + (A_W+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oPlotCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
`default_nettype none
// Bench for vga_plot_sink on a shrunken raster so whole frames fit in the run;
// expectations come from tick arithmetic over a framebuffer array.
module tb_vga_plot_sink;
    localparam int XB = 4, YB = 3, HO = 10, VO = 5;
    localparam int HV = 40, HF = 4, HS = 6, HB = 6;
    localparam int VV = 20, VF = 2, VS = 2, VB = 3;
    localparam int D  = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int W  = 1 << XB, H = 1 << YB, NPIX = W * H;

    logic clock = 1'b0;
    logic not_reset = 1'b0;
    logic [7:0] oVgaR, oVgaG, oVgaB;
    logic oHsync, oVsync, oBlankN, oPixelEn, oFrameStart;
    logic [XB+YB:0] oPlotCount;

    vga_plot_sink_if #(.X_BITS(XB), .Y_BITS(YB)) pif ();

    vga_plot_sink #(
        .X_BITS(XB), .Y_BITS(YB), .H_OFFSET(HO), .V_OFFSET(VO),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(D)
    ) dut (
        .clock(clock), .not_reset(not_reset), .plot_i(pif),
        .oVgaR(oVgaR), .oVgaG(oVgaG), .oVgaB(oVgaB),
        .oHsync(oHsync), .oVsync(oVsync), .oBlankN(oBlankN),
        .oPixelEn(oPixelEn), .oFrameStart(oFrameStart), .oPlotCount(oPlotCount)
    );

    always #5 clock = ~clock;

    int n = 0;      // clock edges since reset release
    int cyc = 0;
    always @(posedge clock or negedge not_reset)
        if (!not_reset) n <= 0; else n <= n + 1;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int exp_cnt = 0;
    int last_wr = -100;
    logic [8:0] mfb [NPIX];

    typedef struct {
        bit wr; int x; int y; logic [2:0] r; logic [2:0] g; logic [2:0] b;
        int h; int v; logic [7:0] er; logic [7:0] eg; logic [7:0] eb; logic ebl;
    } vec_t;
    localparam int NV = 11;
    vec_t vt [NV];

    // 3-bit level scaled onto 0..255
    function automatic logic [7:0] x3(input logic [2:0] c);
        int v;
        v = (int'(c) * 255 + 3) / 7;
        return v[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_out(input int nn, output logic hs, output logic vs, output logic bl,
                             output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                             output logic pe, output logic fs);
        int t, q, h, v;
        logic [8:0] px;
        t  = nn / D;
        pe = (nn % D) == D - 1;
        fs = pe && (t % FT == 0);
        hs = 1'b1; vs = 1'b1; bl = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00;
        if (t >= 2) begin
            q  = (t - 2) % FT;
            h  = q % HT;
            v  = q / HT;
            hs = !(h >= HV + HF && h < HV + HF + HS);
            vs = !(v >= VV + VF && v < VV + VF + VS);
            bl = (h < HV) && (v < VV);
            if (bl && h >= HO && h < HO + W && v >= VO && v < VO + H) begin
                px = mfb[(v - VO) * W + (h - HO)];
                r = x3(px[8:6]); g = x3(px[5:3]); b = x3(px[2:0]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic ehs, evs, ebl, epe, efs;
        logic [7:0] er, eg, eb;
        model_out(n, ehs, evs, ebl, er, eg, eb, epe, efs);
        checks++;
        if ({oHsync, oVsync, oBlankN, oPixelEn, oFrameStart, oVgaR, oVgaG, oVgaB} !==
            {ehs, evs, ebl, epe, efs, er, eg, eb}) begin
            errors++;
            $display("FAIL %s n=%0d got hs=%b vs=%b bl=%b pe=%b fs=%b rgb=%h/%h/%h expected hs=%b vs=%b bl=%b pe=%b fs=%b rgb=%h/%h/%h",
                     tag, n, oHsync, oVsync, oBlankN, oPixelEn, oFrameStart, oVgaR, oVgaG, oVgaB,
                     ehs, evs, ebl, epe, efs, er, eg, eb);
        end
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic plot(input int x, input int y, input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
        pif.iX = x[XB-1:0]; pif.iY = y[YB-1:0];
        pif.iR = r; pif.iG = g; pif.iB = b; pif.iPlot = 1'b1;
        mfb[y * W + x] = {r, g, b};
        if (exp_cnt < NPIX) exp_cnt++;
        last_wr = cyc;
        @(negedge clock);
        pif.iPlot = 1'b0;
    endtask

    task automatic wait_n(input int target);
        int budget;
        budget = 4 * FT * D;
        while (n < target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (n != target) begin
            checks++; errors++;
            $display("FAIL wait_n: reached %0d expected %0d", n, target);
        end
    endtask

    // which: 0 = hsync, 1 = vsync, 2 = frame start
    task automatic wait_sig(input int which, input logic val, input int limit);
        int budget;
        logic s;
        budget = limit;
        s = (which == 0) ? oHsync : (which == 1) ? oVsync : oFrameStart;
        while (s !== val && budget > 0) begin
            @(negedge clock);
            budget--;
            s = (which == 0) ? oHsync : (which == 1) ? oVsync : oFrameStart;
        end
        if (s !== val) begin
            checks++; errors++;
            $display("FAIL wait_sig%0d: got %b expected %b", which, s, val);
        end
    endtask

    // First sample point at which display pixel (h,v) sits on the outputs,
    // at least three ticks in the future.
    function automatic int disp_n(input int h, input int v);
        int k, cur;
        cur = n / D;
        k   = v * HT + h + 2;
        while (k < cur + 3) k += FT;
        return k * D;
    endfunction

    initial begin
        int t0, k;
        vt[0]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, 0,       0,       8'h00, 8'h00, 8'h00, 1'b1};
        vt[1]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HV + 2,  3,       8'h00, 8'h00, 8'h00, 1'b0};
        vt[2]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HO,      VO - 1,  8'h00, 8'h00, 8'h00, 1'b1};
        vt[3]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HO - 1,  VO,      8'h00, 8'h00, 8'h00, 1'b1};
        vt[4]  = '{1, 0, 0, 3'd7, 3'd0, 3'd5, HO,      VO,      8'hFF, 8'h00, 8'hB6, 1'b1};
        vt[5]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HO + 1,  VO,      8'h00, 8'h00, 8'h00, 1'b1};
        vt[6]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HO + 5,  VO,      8'hDB, 8'hDB, 8'hDB, 1'b1};
        vt[7]  = '{1, 3, 2, 3'd3, 3'd4, 3'd1, HO + 3,  VO + 2,  8'h6D, 8'h92, 8'h24, 1'b1};
        vt[8]  = '{1, 15, 7, 3'd7, 3'd7, 3'd7, HO + 15, VO + 7, 8'hFF, 8'hFF, 8'hFF, 1'b1};
        vt[9]  = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HO + 16, VO + 7,  8'h00, 8'h00, 8'h00, 1'b1};
        vt[10] = '{0, 0, 0, 3'd0, 3'd0, 3'd0, HO,      VV,      8'h00, 8'h00, 8'h00, 1'b0};

        pif.iX = '0; pif.iY = '0; pif.iR = '0; pif.iG = '0; pif.iB = '0; pif.iPlot = 1'b0;
        for (int i = 0; i < NPIX; i++) mfb[i] = 9'd0;

        repeat (3) @(negedge clock);
        chk("rst_hsync", oHsync, 1);
        chk("rst_vsync", oVsync, 1);
        chk("rst_blank", oBlankN, 0);
        chk("rst_rgb", {oVgaR, oVgaG, oVgaB}, 0);
        chk("rst_pixen", oPixelEn, 0);
        chk("rst_fstart", oFrameStart, 0);
        chk("rst_count", oPlotCount, 0);
        not_reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("pixen%0d", i), oPixelEn, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("fstart%0d", i), oFrameStart, (i == 0) ? 1 : 0);
        end

        for (int a = 0; a < NPIX; a++) plot(a % W, a / W, 3'd0, 3'd0, 3'd0);
        chk("count_full", oPlotCount, NPIX);

        // Random plots for one frame, then a quiet frame, all checked against the model
        for (int c = 0; c < 2 * FT * D; c++) begin
            if (c < FT * D && $urandom_range(0, 7) == 0)
                plot($urandom_range(0, W - 1), $urandom_range(0, H - 1),
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            else
                @(negedge clock);
            if (cyc - last_wr > 8) check_all("scan");
        end

        for (int a = 0; a < NPIX; a++) plot(a % W, a / W, 3'd0, 3'd0, 3'd0);
        plot(5, 0, 3'd1, 3'd1, 3'd1);
        plot(5, 0, 3'd2, 3'd2, 3'd2);
        plot(5, 0, 3'd3, 3'd3, 3'd3);
        plot(5, 0, 3'd6, 3'd6, 3'd6);
        chk("count_sat", oPlotCount, NPIX);
        chk("count_model", oPlotCount, exp_cnt);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].wr) plot(vt[i].x, vt[i].y, vt[i].r, vt[i].g, vt[i].b);
            wait_n(disp_n(vt[i].h, vt[i].v));
            chk($sformatf("vec%0d_R", i), oVgaR, vt[i].er);
            chk($sformatf("vec%0d_G", i), oVgaG, vt[i].eg);
            chk($sformatf("vec%0d_B", i), oVgaB, vt[i].eb);
            chk($sformatf("vec%0d_blank", i), oBlankN, vt[i].ebl);
        end

        // Sync and frame periods in clocks
        wait_sig(0, 1'b1, 4 * HT * D);
        wait_sig(0, 1'b0, 4 * HT * D);
        t0 = cyc;
        wait_sig(0, 1'b1, 4 * HT * D);
        chk("hsync_low", cyc - t0, HS * D);
        wait_sig(0, 1'b0, 4 * HT * D);
        chk("hsync_period", cyc - t0, HT * D);
        wait_sig(1, 1'b1, 2 * FT * D);
        wait_sig(1, 1'b0, 2 * FT * D);
        t0 = cyc;
        wait_sig(1, 1'b1, 2 * FT * D);
        chk("vsync_low", cyc - t0, VS * HT * D);
        wait_sig(2, 1'b1, 2 * FT * D);
        t0 = cyc;
        @(negedge clock);
        wait_sig(2, 1'b1, 2 * FT * D);
        chk("frame_period", cyc - t0, FT * D);

        // Write lands on the same clock the scan reads that address
        k = disp_n(HO + 3, VO + 2) / D;
        wait_n((k - 1) * D - 1);
        pif.iX = 4'd3; pif.iY = 3'd2; pif.iR = 3'd7; pif.iG = 3'd0; pif.iB = 3'd0; pif.iPlot = 1'b1;
        @(negedge clock);
        pif.iPlot = 1'b0;
        mfb[2 * W + 3] = 9'b111_000_000;
        if (exp_cnt < NPIX) exp_cnt++;
        last_wr = cyc;
        wait_n(k * D);
        chk("collide_old", {oVgaR, oVgaG, oVgaB}, 24'h6D9224);
        wait_n(k * D + FT * D);
        chk("collide_new", {oVgaR, oVgaG, oVgaB}, 24'hFF0000);

        // Reset while hsync is low, mid-frame
        wait_n(disp_n(HV + HF + 1, 3));
        chk("pre_rst_hsync", oHsync, 0);
        not_reset = 1'b0;
        #1;
        chk("mid_rst_hsync", oHsync, 1);
        chk("mid_rst_vsync", oVsync, 1);
        chk("mid_rst_blank", oBlankN, 0);
        chk("mid_rst_rgb", {oVgaR, oVgaG, oVgaB}, 0);
        chk("mid_rst_count", oPlotCount, 0);
        exp_cnt = 0;
        @(negedge clock);
        not_reset = 1'b1;
        @(negedge clock);
        chk("post_rst_pixen", oPixelEn, 1);
        chk("post_rst_fstart", oFrameStart, 1);
        for (int c = 0; c < FT * D + 8; c++) begin
            check_all("post_rst");
            @(negedge clock);
        end
        wait_n(disp_n(HO, VO));
        chk("kept_pixel", {oVgaR, oVgaG, oVgaB, 7'd0, oBlankN}, 32'hFF00B601);
        chk("post_rst_count", oPlotCount, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
